// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the round-robin mux arbiter.
package mux_arb_pkg;

    localparam int unsigned NUM_REQ     = 8;
    localparam int unsigned SEL_W       = 3;
    localparam int unsigned TIMEOUT_DEF = 16;
    localparam int unsigned WDOG_W      = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux_8x1.sv
// 8:1 single-bit select mux shared by all requesters.
module mux_8x1
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_a,
    input  logic [SEL_W-1:0]   i_sel,
    output logic               o_y_c
);

    assign o_y_c = i_a[i_sel];

endmodule

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request scanning from ptr upward, modulo NUM_REQ.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [SEL_W-1:0]   i_ptr,
    output logic [SEL_W-1:0]   o_idx_c,
    output logic               o_any_c
);

    logic [SEL_W-1:0] w_cand;

    // Scan from the farthest offset down so the nearest set bit to ptr wins.
    always_comb begin
        o_idx_c = '0;
        o_any_c = 1'b0;
        w_cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = i_ptr + SEL_W'(k);
            if (i_req[w_cand]) begin
                o_idx_c = w_cand;
                o_any_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared mux_8x1 with valid/ready output and grant watchdog.
// Optional hold-grant lock input enabled by defining MUX_ARB_LOCK_EN.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] a,
`ifdef MUX_ARB_LOCK_EN
    input  logic               lock,
`endif
    input  logic               out_ready,
    output logic               out_valid,
    output logic               y,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] ack,
    output logic               timeout
);

    arb_state_t          r_state;
    logic [SEL_W-1:0]    r_ptr;
    logic [SEL_W-1:0]    r_sel;
    logic [WDOG_W-1:0]   r_wdog;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_ack;
    logic                r_out_valid;
    logic                r_timeout;

    logic [SEL_W-1:0]    w_idx;
    logic                w_any;
    logic                w_xfer;
    logic                w_lock;

`ifdef MUX_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_xfer = r_out_valid && out_ready;

    rr_pick u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_idx_c (w_idx),
        .o_any_c (w_any)
    );

    mux_8x1 u_mux (
        .i_a   (a),
        .i_sel (r_sel),
        .o_y_c (y)
    );

    // Arbitration FSM; a transfer outranks both abort and watchdog expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_wdog      <= '0;
            r_grant     <= '0;
            r_ack       <= '0;
            r_out_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_ack     <= '0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state     <= GRANT;
                        r_sel       <= w_idx;
                        r_grant     <= NUM_REQ'(1) << w_idx;
                        r_out_valid <= 1'b1;
                        r_wdog      <= '0;
                    end
                end
                GRANT: begin
                    if (w_xfer) begin
                        r_ack <= r_grant;
                        if (w_lock && req[r_sel]) begin
                            r_wdog <= '0;
                        end else begin
                            r_state     <= IDLE;
                            r_grant     <= '0;
                            r_out_valid <= 1'b0;
                            r_ptr       <= r_sel + SEL_W'(1);
                        end
                    end else if (!req[r_sel]) begin
                        r_state     <= IDLE;
                        r_grant     <= '0;
                        r_out_valid <= 1'b0;
                    end else if (r_wdog == WDOG_W'(TIMEOUT - 1)) begin
                        r_timeout   <= 1'b1;
                        r_state     <= IDLE;
                        r_grant     <= '0;
                        r_out_valid <= 1'b0;
                        r_ptr       <= r_sel + SEL_W'(1);
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign sel       = r_sel;
    assign grant     = r_grant;
    assign ack       = r_ack;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: per-cycle reference model plus directed literal checks.
module tb_mux_rr_arbiter;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] a   = 8'h00;
    logic       out_ready = 1'b0;
    logic       lock = 1'b0;
    logic       out_valid, y, timeout;
    logic [2:0] sel;
    logic [7:0] grant, ack;

    int checks = 0;
    int errors = 0;
    int ack_log[$];

    // reference model state
    bit         started = 1'b0;
    bit         m_busy  = 1'b0;
    int         m_sel   = 0;
    int         m_ptr   = 0;
    int         m_age   = 0;
    logic [7:0] e_ack   = 8'h00;
    bit         e_to    = 1'b0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a         (a),
`ifdef MUX_ARB_LOCK_EN
        .lock      (lock),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid),
        .y         (y),
        .sel       (sel),
        .grant     (grant),
        .ack       (ack),
        .timeout   (timeout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_log(input string nm, input int exp_q[$]);
        chk({nm, "_len"}, 32'(ack_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < ack_log.size(); i++)
            chk({nm, "_item"}, 32'(ack_log[i]), 32'(exp_q[i]));
    endtask

    // Next-state of the model from the inputs seen at this rising edge.
    task automatic model_step();
        bit lk;
        bit found;
`ifdef MUX_ARB_LOCK_EN
        lk = lock;
`else
        lk = 1'b0;
`endif
        e_ack = 8'h00;
        e_to  = 1'b0;
        if (rst) begin
            started = 1'b1;
            m_busy = 1'b0; m_sel = 0; m_ptr = 0; m_age = 0;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (m_ptr + k) % 8;
                if (!found && req[c]) begin
                    found = 1'b1;
                    m_sel = c;
                end
            end
            if (found) begin
                m_busy = 1'b1;
                m_age  = 0;
            end
        end else if (out_ready) begin
            e_ack[m_sel] = 1'b1;
            if (lk && req[m_sel]) m_age = 0;
            else begin
                m_busy = 1'b0;
                m_ptr  = (m_sel + 1) % 8;
            end
        end else if (!req[m_sel]) begin
            m_busy = 1'b0;
        end else if (m_age == TMO - 1) begin
            e_to   = 1'b1;
            m_busy = 1'b0;
            m_ptr  = (m_sel + 1) % 8;
        end else begin
            m_age++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare every cycle on the falling edge and log completed transfers.
    initial forever begin
        logic [7:0] eg;
        @(negedge clk);
        if (started) begin
            eg = m_busy ? (8'h01 << m_sel) : 8'h00;
            chk("out_valid", 32'(out_valid), 32'(m_busy));
            chk("sel", 32'(sel), 32'(m_sel));
            chk("grant", 32'(grant), 32'(eg));
            chk("ack", 32'(ack), 32'(e_ack));
            chk("timeout", 32'(timeout), 32'(e_to));
            chk("y", 32'(y), 32'(a[m_sel]));
            for (int i = 0; i < 8; i++)
                if (ack[i]) ack_log.push_back(i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int vcnt, tcnt, acnt;
        int q[$];

        // reset values
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        rst = 1'b0;

        // single requester
        req = 8'h04; a = 8'hAA; out_ready = 1'b1;
        tick();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_sel", 32'(sel), 32'd2);
        chk("single_y", 32'(y), 32'd0);
        chk("single_grant", 32'(grant), 32'h04);
        tick();
        chk("single_ack", 32'(ack), 32'h04);
        chk("single_valid_lo", 32'(out_valid), 32'd0);
        req = 8'h00;
        tick();

        // fairness from ptr=0
        rst = 1'b1; tick(); rst = 1'b0;
        ack_log.delete();
        req = 8'hFF; a = 8'h5C;
        for (int i = 0; i < 18; i++) tick();
        req = 8'h00;
        tick();
        q = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        chk_log("fair_order", q);

        // wrap-around: serve 6, then 7 and 0 pending
        ack_log.delete();
        req = 8'h40;
        tick(); tick();
        req = 8'h81;
        for (int i = 0; i < 4; i++) tick();
        req = 8'h00;
        tick();
        q = '{6, 7, 0};
        chk_log("wrap_order", q);

        // watchdog with 3 and 5 pending, ptr=1
        ack_log.delete();
        req = 8'h28; out_ready = 1'b0;
        vcnt = 0; tcnt = 0;
        for (int i = 0; i < 17; i++) begin
            tick();
            vcnt += int'(out_valid);
            tcnt += int'(timeout);
        end
        chk("wdog_valid_cycles", 32'(vcnt), 32'd16);
        chk("wdog_timeout_pulses", 32'(tcnt), 32'd1);
        req = 8'h20; out_ready = 1'b1;
        tick();
        chk("wdog_next_sel", 32'(sel), 32'd5);
        tick();
        req = 8'h00;
        tick();
        q = '{5};
        chk_log("wdog_acks", q);

        // abort on requester 7 keeps ptr at 6
        ack_log.delete();
        req = 8'h80; out_ready = 1'b0;
        tick();
        chk("abort_grant", 32'(grant), 32'h80);
        req = 8'h00;
        tick();
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_ack", 32'(ack), 32'd0);
        req = 8'h41; out_ready = 1'b1;
        tick();
        chk("abort_next_sel", 32'(sel), 32'd6);
        tick();
        req = 8'h00;
        tick();
        q = '{6};
        chk_log("abort_acks", q);

        // reset mid-grant
        req = 8'h01; out_ready = 1'b0;
        tick();
        chk("midrst_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_timeout", 32'(timeout), 32'd0);
        rst = 1'b0; req = 8'h00;
        tick();

`ifdef MUX_ARB_LOCK_EN
        // locked back-to-back transfers on requester 1
        req = 8'h02; lock = 1'b1; out_ready = 1'b1;
        tick();
        acnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ack == 8'h02 && sel == 3'd1 && out_valid) acnt++;
        end
        chk("lock_acks", 32'(acnt), 32'd4);
        lock = 1'b0;
        tick();
        chk("lock_release_ack", 32'(ack), 32'h02);
        chk("lock_release_valid", 32'(out_valid), 32'd0);
        req = 8'h00;
        tick();
`else
        acnt = 0;
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
